// File: rtl/clk_rst_seq.sv
// Reset sequencer for clk_sys: filters the raw MMCM lock, then releases the core
// reset and, later, the peripheral reset; re-asserts both on lock loss or software request.
module clk_rst_seq #(
  parameter int HOLD_CYCLES  = 16,
  parameter int PERIPH_DELAY = 8
) (
  input  logic       clk_sys,
  input  logic       rst,
  input  logic       locked_in,
  input  logic       sw_reset_req,
  output logic       rst_core,
  output logic       rst_periph,
  output logic       ready,
  output logic [7:0] loss_count
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int PW = $clog2(PERIPH_DELAY + 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);
  localparam logic [PW-1:0] PERIPH_LAST = PW'(PERIPH_DELAY - 1);

  typedef enum logic [1:0] {WAIT_LOCK, CORE, RUN} state_t;

  state_t          r_state, w_state_next;
  logic            r_sync0, r_lock_s;
  logic [HW-1:0]   r_hold_cnt, w_hold_next;
  logic [PW-1:0]   r_periph_cnt, w_periph_next;
  logic            w_loss_inc;
  logic            r_rst_core, r_rst_periph, r_ready;
  logic [7:0]      r_loss_count;

  // locked_in is asynchronous to clk_sys; only the second stage feeds the FSM
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      r_sync0  <= 1'b0;
      r_lock_s <= 1'b0;
    end else begin
      r_sync0  <= locked_in;
      r_lock_s <= r_sync0;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_hold_next   = r_hold_cnt;
    w_periph_next = r_periph_cnt;
    w_loss_inc    = 1'b0;
    case (r_state)
      WAIT_LOCK: begin
        w_periph_next = '0;
        if (!r_lock_s || sw_reset_req) begin
          w_hold_next = '0;
        end else if (r_hold_cnt == HOLD_LAST) begin
          w_state_next = CORE;
          w_hold_next  = '0;
        end else begin
          w_hold_next = r_hold_cnt + HW'(1);
        end
      end
      CORE, RUN: begin
        // lock loss outranks both the software request and the CORE->RUN step
        if (!r_lock_s) begin
          w_state_next  = WAIT_LOCK;
          w_hold_next   = '0;
          w_periph_next = '0;
          w_loss_inc    = 1'b1;
        end else if (sw_reset_req) begin
          w_state_next  = WAIT_LOCK;
          w_hold_next   = '0;
          w_periph_next = '0;
        end else if (r_state == CORE) begin
          if (r_periph_cnt == PERIPH_LAST) begin
            w_state_next  = RUN;
            w_periph_next = '0;
          end else begin
            w_periph_next = r_periph_cnt + PW'(1);
          end
        end
      end
      default: begin
        w_state_next  = WAIT_LOCK;
        w_hold_next   = '0;
        w_periph_next = '0;
      end
    endcase
  end

  // Outputs decode the next state so they move on the same edge as the transition
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      r_state      <= WAIT_LOCK;
      r_hold_cnt   <= '0;
      r_periph_cnt <= '0;
      r_rst_core   <= 1'b1;
      r_rst_periph <= 1'b1;
      r_ready      <= 1'b0;
      r_loss_count <= 8'd0;
    end else begin
      r_state      <= w_state_next;
      r_hold_cnt   <= w_hold_next;
      r_periph_cnt <= w_periph_next;
      r_rst_core   <= (w_state_next == WAIT_LOCK);
      r_rst_periph <= (w_state_next != RUN);
      r_ready      <= (w_state_next == RUN);
      if (w_loss_inc && (r_loss_count != 8'hFF)) begin
        r_loss_count <= r_loss_count + 8'd1;
      end
    end
  end

  assign rst_core   = r_rst_core;
  assign rst_periph = r_rst_periph;
  assign ready      = r_ready;
  assign loss_count = r_loss_count;

endmodule
